exec_cycle_ctrl: RTL and testbench

Multi-cycle execution controller for the single-issue MIPS-subset datapath. It sequences each accepted instruction through DECODE, EXEC, MEM and WB. It drives the control strobes consumed by the register file, ALU and data-memory port (ALUSrc, ALUOp, MemRead, MemWrite, RegWrite, MemtoReg, RegDst). It also reports completion, illegal opcodes and memory-access timeouts back to the fetch side.

---
 rtl/exec_ctrl_pkg.sv | 77 +++++++
 rtl/exec_ctrl_decode.sv | 24 ++
 rtl/exec_cycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_exec_cycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the multi-cycle execution controller.
// Optional beq support is selected with EXEC_CTRL_BRANCH_EN.
package exec_ctrl_pkg;

  localparam int unsigned INSTR_W             = 32;
  localparam int unsigned OPCODE_W            = 6;
  localparam int unsigned ALUOP_W             = 2;
  localparam int unsigned STATE_W             = 3;
  localparam int unsigned TIMEOUT_W           = 8;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    IC_RTYPE,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               reg_dst;
  } ctrl_t;

  // Control strobes implied by a state and the class of the held instruction.
  function automatic ctrl_t ctrl_for(input state_t st, input iclass_t ic);
    ctrl_t c;
    c = '0;
    case (st)
      ST_EXEC, ST_MEM: begin
        case (ic)
          IC_LOAD, IC_STORE: begin
            c.alu_src = 1'b1;
            c.alu_op  = ALUOP_ADD;
          end
          IC_RTYPE:  c.alu_op = ALUOP_FUNCT;
          IC_BRANCH: c.alu_op = ALUOP_SUB;
          default:   c.alu_op = ALUOP_ADD;
        endcase
        if (st == ST_MEM) begin
          c.mem_read  = (ic == IC_LOAD);
          c.mem_write = (ic == IC_STORE);
        end
      end
      ST_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (ic == IC_LOAD);
        c.reg_dst    = (ic == IC_RTYPE);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_ctrl_decode.sv
// Opcode to instruction-class decode; beq is legal only with EXEC_CTRL_BRANCH_EN.
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             iclass_c
);

  always_comb begin
    iclass_c = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: iclass_c = IC_RTYPE;
      OP_LW:    iclass_c = IC_LOAD;
      OP_SW:    iclass_c = IC_STORE;
`ifdef EXEC_CTRL_BRANCH_EN
      OP_BEQ:   iclass_c = IC_BRANCH;
`else
      OP_BEQ:   iclass_c = IC_ILLEGAL;
`endif
      default:  iclass_c = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/exec_cycle_ctrl.sv
// Multi-cycle DECODE/EXEC/MEM/WB sequencer with registered strobes and status pulses.
// Define EXEC_CTRL_BRANCH_EN to support beq; otherwise its opcode is illegal.
module exec_cycle_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_ready,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               ir_write,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               done,
  output logic               illegal,
  output logic               mem_err,
  output logic               branch_taken,
  output logic [STATE_W-1:0] state
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  state_t                state_q, state_n;
  logic [OPCODE_W-1:0]   op_q, op_n;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_n, cnt_inc;
  ctrl_t                 ctrl_q, ctrl_n;
  logic                  ready_q, ready_n;
  logic                  done_q, done_n;
  logic                  illegal_q, illegal_n;
  logic                  mem_err_q, mem_err_n;
  logic                  taken_q, taken_n;
  iclass_t               iclass_c;
  logic                  handshake_c;

  // Only the opcode field steers the controller; the rest belongs to the datapath IR.
  logic [INSTR_W-OPCODE_W-1:0] unused_instr;
  assign unused_instr = instruction[INSTR_W-OPCODE_W-1:0];

  exec_ctrl_decode u_decode (
    .opcode   (op_q),
    .iclass_c (iclass_c)
  );

  assign handshake_c = instr_valid & ready_q & reset;
  assign cnt_inc     = cnt_q + TIMEOUT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      cnt_q     <= cnt_n;
      ctrl_q    <= ctrl_n;
      ready_q   <= ready_n;
      done_q    <= done_n;
      illegal_q <= illegal_n;
      mem_err_q <= mem_err_n;
      taken_q   <= taken_n;
    end
  end

  // Next state, IR/counter updates, and next-cycle strobes and pulses.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    cnt_n     = cnt_q;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    mem_err_n = 1'b0;
    taken_n   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (handshake_c) begin
          op_n    = instruction[INSTR_W-1 -: OPCODE_W];
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (iclass_c == IC_ILLEGAL) begin
          state_n   = ST_IDLE;
          illegal_n = 1'b1;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass_c)
          IC_LOAD, IC_STORE: begin
            state_n = ST_MEM;
            cnt_n   = '0;
          end
          IC_RTYPE: state_n = ST_WB;
          IC_BRANCH: begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            taken_n = zero;
          end
          default: state_n = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        // A completing access takes priority over the timeout in the same cycle.
        if (mem_ready) begin
          if (iclass_c == IC_STORE) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_WB;
          end
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          state_n   = ST_IDLE;
          mem_err_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_WB: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    ctrl_n  = ctrl_for(state_n, iclass_c);
    ready_n = (state_n == ST_IDLE);
  end

  assign instr_ready = ready_q;
  assign ir_write    = handshake_c;
  assign alu_src     = ctrl_q.alu_src;
  assign alu_op      = ctrl_q.alu_op;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_dst     = ctrl_q.reg_dst;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign mem_err     = mem_err_q;
  assign state       = state_q;

`ifdef EXEC_CTRL_BRANCH_EN
  assign branch_taken = taken_q;
`else
  logic unused_branch;
  assign unused_branch = taken_q ^ zero;
  assign branch_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_exec_cycle_ctrl.sv
// Self-checking bench: per-cycle expected traces built from instruction-level timing rules.
module tb_exec_cycle_ctrl;

  localparam int unsigned T = 15;
`ifdef EXEC_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       instr_ready;
    logic       ir_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       done;
    logic       illegal;
    logic       mem_err;
    logic       branch_taken;
    logic [2:0] state;
  } tb_out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        instr_ready, ir_write, alu_src, mem_read, mem_write, reg_write;
  logic        mem_to_reg, reg_dst, done, illegal, mem_err, branch_taken;
  logic [1:0]  alu_op;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tb_out_t     exp_q[$];
  logic        v_q[$];
  logic [31:0] i_q[$];
  logic        mr_q[$];
  logic        z_q[$];
  logic [3:0]  pend = 4'b0; // {done, illegal, mem_err, branch_taken} due next cycle

  exec_cycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .zero(zero), .ir_write(ir_write),
    .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .done(done),
    .illegal(illegal), .mem_err(mem_err), .branch_taken(branch_taken), .state(state)
  );

  always #5 clk = ~clk;

  function automatic tb_out_t sample();
    tb_out_t o;
    o.instr_ready = instr_ready; o.ir_write = ir_write; o.alu_src = alu_src;
    o.alu_op = alu_op; o.mem_read = mem_read; o.mem_write = mem_write;
    o.reg_write = reg_write; o.mem_to_reg = mem_to_reg; o.reg_dst = reg_dst;
    o.done = done; o.illegal = illegal; o.mem_err = mem_err;
    o.branch_taken = branch_taken; o.state = state;
    return o;
  endfunction

  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic mr,
                             input logic zf, output tb_out_t obs);
    @(negedge clk);
    instr_valid = v; instruction = ins; mem_ready = mr; zero = zf;
    #1;
    obs = sample();
  endtask

  task automatic push(input tb_out_t e, input logic v, input logic [31:0] ins,
                      input logic mr, input logic zf);
    exp_q.push_back(e); v_q.push_back(v); i_q.push_back(ins);
    mr_q.push_back(mr); z_q.push_back(zf);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction: handshake, DECODE, EXEC, MEM.., WB, then idle gap.
  // waitc = MEM cycles with mem_ready low before it rises.
  task automatic add_instr(input logic [31:0] w, input int waitc, input logic zf, input int gap);
    tb_out_t     e;
    logic [5:0]  op;
    int          cls; // 0 R, 1 lw, 2 sw, 3 beq, 4 illegal
    int          n_mem;
    op  = w[31:26];
    cls = (op == 6'h00) ? 0 : (op == 6'h23) ? 1 : (op == 6'h2B) ? 2 :
          (op == 6'h04 && BR_EN) ? 3 : 4;
    e = '0; e.instr_ready = 1'b1; e.ir_write = 1'b1;
    {e.done, e.illegal, e.mem_err, e.branch_taken} = pend;
    push(e, 1'b1, w, rb(), rb());
    e = '0; e.state = 3'd1;
    push(e, rb(), $urandom, rb(), rb());
    if (cls == 4) begin
      pend = 4'b0100;
    end else begin
      e = '0; e.state = 3'd2;
      if (cls == 0) e.alu_op = 2'b10;
      else if (cls == 3) e.alu_op = 2'b01;
      else e.alu_src = 1'b1;
      push(e, rb(), $urandom, rb(), zf);
      if (cls == 3) begin
        pend = {1'b1, 1'b0, 1'b0, zf};
      end else if (cls == 0) begin
        e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.reg_dst = 1'b1;
        push(e, rb(), $urandom, rb(), rb());
        pend = 4'b1000;
      end else begin
        n_mem = (waitc < int'(T)) ? waitc + 1 : int'(T);
        for (int i = 0; i < n_mem; i++) begin
          e = '0; e.state = 3'd3; e.alu_src = 1'b1;
          e.mem_read = (cls == 1); e.mem_write = (cls == 2);
          push(e, rb(), $urandom, (i == waitc), rb());
        end
        if (waitc >= int'(T)) begin
          pend = 4'b0010;
        end else if (cls == 2) begin
          pend = 4'b1000;
        end else begin
          e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          push(e, rb(), $urandom, rb(), rb());
          pend = 4'b1000;
        end
      end
    end
    for (int g = 0; g < gap; g++) begin
      e = '0; e.instr_ready = 1'b1;
      {e.done, e.illegal, e.mem_err, e.branch_taken} = pend;
      push(e, 1'b0, $urandom, rb(), rb());
      pend = 4'b0;
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); v_q.delete(); i_q.delete(); mr_q.delete(); z_q.delete();
  endtask

  task automatic test_reset();
    tb_out_t o, e;
    e = '0; e.instr_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, $urandom, rb(), rb(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    @(negedge clk); reset = 1'b1;
    pend = 4'b0;
  endtask

  task automatic test_directed();
    tb_out_t o, e;
    clear_queues();
    add_instr(32'hAC890004, 0, 1'b0, 1);   // sw, immediate ready
    add_instr(32'h8C890004, 2, 1'b0, 1);   // lw, two wait cycles
    add_instr(32'h01095020, 0, 1'b0, 1);   // R-type add
    add_instr(32'hFC000000, 0, 1'b0, 1);   // unsupported opcode
    add_instr(32'h11090002, 0, 1'b1, 1);   // beq, zero=1
    add_instr(32'h11090002, 0, 1'b0, 1);   // beq, zero=0
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL directed cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_timeout_reset();
    tb_out_t o, e;
    clear_queues();
    add_instr(32'hAC890004, 40, 1'b0, 2);  // sw never acknowledged
    add_instr(32'h8C890004, int'(T) - 1, 1'b0, 1); // ready on the last allowed cycle
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
    // Same stalled sw, reset asserted at N+5 while in MEM.
    clear_queues();
    add_instr(32'hAC890004, 40, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
    #1;
    o = sample();
    e = '0; e.instr_ready = 1'b1;
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL midop_reset got=%h exp=%h", o, e);
    end
    @(negedge clk); reset = 1'b1;
    clear_queues();
    pend = 4'b0;
    add_instr(32'h01095020, 0, 1'b0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    tb_out_t o, e;
    clear_queues();
    add_instr(32'hFC000000, 0, 1'b0, 0);
    add_instr(32'h11090002, 0, 1'b1, 0);
    add_instr(32'hAC890004, int'(T), 1'b0, 0);
    add_instr(32'h8C890004, 1, 1'b0, 0);
    add_instr(32'h01095020, 0, 1'b0, 0);
    add_instr(32'hAC890004, 0, 1'b0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_random();
    tb_out_t     o, e;
    logic [31:0] w;
    int          waitc, r;
    clear_queues();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r <= 2)      w[31:26] = 6'h00;
      else if (r <= 4) w[31:26] = 6'h23;
      else if (r <= 6) w[31:26] = 6'h2B;
      else if (r == 7) w[31:26] = 6'h04;
      r = $urandom_range(0, 7);
      if (r <= 4)      waitc = $urandom_range(0, 3);
      else if (r == 5) waitc = int'(T) - 1;
      else if (r == 6) waitc = int'(T);
      else             waitc = $urandom_range(T + 1, T + 5);
      add_instr(w, waitc, rb(), $urandom_range(0, 2));
    end
    add_instr(32'h01095020, 0, 1'b0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_cycle(v_q.pop_front(), i_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
